// File: rtl/reg_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_access_ctrl_pkg
// Description : Shared widths, slot-state encoding and helpers for the
//               register access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_access_ctrl_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int NUM_REGS   = 4;
    localparam int REG_ADDR_W = 2;
    localparam int STALL_W    = 16;

    // Output slot toward execute: either empty or holding one bundle
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // One-hot decode of a register index
    function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_access_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register outstanding-write tracker. A register committing
//               this cycle is treated as free so dependents issue right away.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import reg_access_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  commit_en,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  uses_rs,
    input  logic                  uses_rt,
    input  logic                  writes_rd,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  hazard
);

    logic [NUM_REGS-1:0] w_commit;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_eff_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    assign w_commit   = commit_en ? onehot_reg(commit_rd) : '0;
    assign w_set      = set_en    ? onehot_reg(set_rd)    : '0;
    assign w_eff_busy = busy_mask & ~w_commit;

    assign hazard = (uses_rs   & w_eff_busy[rs])
                  | (uses_rt   & w_eff_busy[rt])
                  | (writes_rd & w_eff_busy[rd]);

    // A new claim on a register outranks the commit releasing it
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            assign w_busy_next[gi] = w_set[gi] | (busy_mask[gi] & ~w_commit[gi]);
        end
    endgenerate

    // Scoreboard state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= w_busy_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_access_ctrl
// Description : Decode-to-execute operand fetch with hazard stalling, commit
//               bypass, one-entry output slot and registered writeback port.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs,
    input  logic [REG_ADDR_W-1:0] in_rt,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_uses_rs,
    input  logic                  in_uses_rt,
    input  logic                  in_writes_rd,
    output logic [REG_ADDR_W-1:0] rf_r1,
    output logic [REG_ADDR_W-1:0] rf_r2,
    input  logic [WORD_SIZE-1:0]  rf_readData1,
    input  logic [WORD_SIZE-1:0]  rf_readData2,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [WORD_SIZE-1:0]  rf_writeData,
    output logic                  rf_regWrite,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [WORD_SIZE-1:0]  op_a,
    output logic [WORD_SIZE-1:0]  op_b,
    output logic [REG_ADDR_W-1:0] op_rd,
    output logic                  op_writes,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [WORD_SIZE-1:0]  wb_data,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [STALL_W-1:0]    stall_count,
    output logic                  err_wb
);

    slot_state_t          r_state;
    slot_state_t          w_state_next;
    logic                 w_hazard;
    logic                 w_accept;
    logic                 w_wb_hit;
    logic [WORD_SIZE-1:0] w_bypass_a;
    logic [WORD_SIZE-1:0] w_bypass_b;

    assign rf_r1 = in_rs;
    assign rf_r2 = in_rt;

    reg_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .commit_en (rf_regWrite),
        .commit_rd (rf_rd),
        .set_en    (w_accept & in_writes_rd),
        .set_rd    (in_rd),
        .rs        (in_rs),
        .rt        (in_rt),
        .rd        (in_rd),
        .uses_rs   (in_uses_rs),
        .uses_rt   (in_uses_rt),
        .writes_rd (in_writes_rd),
        .busy_mask (busy_mask),
        .hazard    (w_hazard)
    );

    assign in_ready = ~w_hazard & ((r_state == SLOT_EMPTY) | op_ready);
    assign w_accept = in_valid & in_ready;
    assign op_valid = (r_state == SLOT_FULL);
    assign w_wb_hit = wb_valid & busy_mask[wb_rd];

    // The value being written this cycle is not yet visible on the read port
    assign w_bypass_a = (rf_regWrite && rf_rd == in_rs) ? rf_writeData : rf_readData1;
    assign w_bypass_b = (rf_regWrite && rf_rd == in_rt) ? rf_writeData : rf_readData2;

    // Output slot state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output slot next state; a refill while draining keeps the slot full
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SLOT_EMPTY: if (w_accept) w_state_next = SLOT_FULL;
            SLOT_FULL:  if (op_ready && !w_accept) w_state_next = SLOT_EMPTY;
            default:    w_state_next = SLOT_EMPTY;
        endcase
    end

    // Operand bundle captured on accept, held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            op_rd     <= '0;
            op_writes <= 1'b0;
        end else if (w_accept) begin
            op_a      <= w_bypass_a;
            op_b      <= w_bypass_b;
            op_rd     <= in_rd;
            op_writes <= in_writes_rd;
        end
    end

    // Writeback register: one-cycle write pulse for results with a pending claim
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_regWrite  <= 1'b0;
            rf_rd        <= '0;
            rf_writeData <= '0;
        end else begin
            rf_regWrite <= w_wb_hit;
            if (w_wb_hit) begin
                rf_rd        <= wb_rd;
                rf_writeData <= wb_data;
            end
        end
    end

    // Saturating hazard-stall counter and sticky spurious-writeback flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            err_wb      <= 1'b0;
        end else begin
            if (in_valid && w_hazard && stall_count != {STALL_W{1'b1}}) begin
                stall_count <= stall_count + 16'd1;
            end
            if (wb_valid && !busy_mask[wb_rd]) begin
                err_wb <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_access_ctrl
// Description : Self-checking bench for reg_access_ctrl with a register-file
//               model and an expected-bundle queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_access_ctrl;
    import reg_access_ctrl_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  rd;
        logic        w;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready;
    logic [1:0]  in_rs, in_rt, in_rd;
    logic        in_uses_rs, in_uses_rt, in_writes_rd;
    logic [1:0]  rf_r1, rf_r2, rf_rd;
    logic [15:0] rf_readData1, rf_readData2, rf_writeData;
    logic        rf_regWrite;
    logic        op_valid, op_ready;
    logic [15:0] op_a, op_b;
    logic [1:0]  op_rd;
    logic        op_writes;
    logic        wb_valid;
    logic [1:0]  wb_rd;
    logic [15:0] wb_data;
    logic [3:0]  busy_mask;
    logic [15:0] stall_count;
    logic        err_wb;

    int          checks;
    int          failures;
    int          exp_stall;
    exp_t        exp_q[$];
    exp_t        e;

    logic [15:0] regs [4];
    logic        pl_en;
    logic [1:0]  pl_idx;
    logic [15:0] pl_val;

    reg_access_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_writes_rd(in_writes_rd),
        .rf_r1(rf_r1), .rf_r2(rf_r2),
        .rf_readData1(rf_readData1), .rf_readData2(rf_readData2),
        .rf_rd(rf_rd), .rf_writeData(rf_writeData), .rf_regWrite(rf_regWrite),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_writes(op_writes),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy_mask(busy_mask), .stall_count(stall_count), .err_wb(err_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational reads, write on posedge
    assign rf_readData1 = regs[rf_r1];
    assign rf_readData2 = regs[rf_r2];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= 16'h0000;
        end else begin
            if (rf_regWrite) regs[rf_rd] <= rf_writeData;
            if (pl_en)       regs[pl_idx] <= pl_val;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_uses_rs = 0; in_uses_rt = 0; in_writes_rd = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic drive(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                         input logic urs, input logic urt, input logic wrd);
        in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd;
        in_uses_rs = urs; in_uses_rt = urt; in_writes_rd = wrd;
    endtask

    task automatic preload(input logic [1:0] idx, input logic [15:0] val);
        pl_en = 1; pl_idx = idx; pl_val = val;
        step();
        pl_en = 0;
    endtask

    task automatic test_reset();
        reset = 1; op_ready = 0; pl_en = 0; pl_idx = 0; pl_val = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({op_valid, op_a, op_b, op_rd, op_writes, rf_regWrite, rf_rd, rf_writeData,
             busy_mask, stall_count, err_wb} !== '0) begin
            failures++;
            $display("FAIL reset_state: got op_valid=%b op_a=%h busy=%b stall=%h err=%b expected all zero",
                     op_valid, op_a, busy_mask, stall_count, err_wb);
        end
        reset = 0;
        exp_stall = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_independent();
        preload(2'd1, 16'h0005);
        preload(2'd2, 16'h0007);
        op_ready = 1;
        drive(2'd1, 2'd2, 2'd3, 1, 1, 1);
        exp_q.push_back('{a:16'h0005, b:16'h0007, rd:2'd3, w:1'b1});
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL indep_ready: got %b expected 1", in_ready);
        end
        step();
        idle_inputs();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({op_valid, op_a, op_b, op_rd, op_writes} !== {1'b1, e.a, e.b, e.rd, e.w}) begin
            failures++;
            $display("FAIL indep_bundle: got v=%b a=%h b=%h rd=%0d w=%b expected v=1 a=%h b=%h rd=%0d w=%b",
                     op_valid, op_a, op_b, op_rd, op_writes, e.a, e.b, e.rd, e.w);
        end
        checks++;
        if (busy_mask !== 4'b1000) begin
            failures++;
            $display("FAIL indep_busy: got %b expected 1000", busy_mask);
        end
        step();
        wb_valid = 1; wb_rd = 2'd3; wb_data = 16'h1234;
        step();
        wb_valid = 0;
        @(negedge clk);
        checks++;
        if ({rf_regWrite, rf_rd, rf_writeData} !== {1'b1, 2'd3, 16'h1234}) begin
            failures++;
            $display("FAIL wb_write: got we=%b rd=%0d data=%h expected we=1 rd=3 data=1234",
                     rf_regWrite, rf_rd, rf_writeData);
        end
        checks++;
        if (busy_mask !== 4'b1000) begin
            failures++;
            $display("FAIL busy_until_commit: got %b expected 1000", busy_mask);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rf_regWrite, busy_mask} !== {1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL wb_single_cycle: got we=%b busy=%b expected we=0 busy=0000", rf_regWrite, busy_mask);
        end
    endtask

    task automatic test_raw_stall();
        op_ready = 1;
        drive(2'd0, 2'd0, 2'd1, 0, 0, 1);
        exp_q.push_back('{a:16'h0000, b:16'h0000, rd:2'd1, w:1'b1});
        step();
        drive(2'd1, 2'd0, 2'd2, 1, 0, 1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL raw_stall_ready: got %b expected 0", in_ready);
        end
        e = exp_q.pop_front();
        checks++;
        if ({op_valid, op_a, op_rd, op_writes} !== {1'b1, e.a, e.rd, e.w}) begin
            failures++;
            $display("FAIL raw_producer: got v=%b a=%h rd=%0d expected v=1 a=%h rd=%0d",
                     op_valid, op_a, op_rd, e.a, e.rd);
        end
        repeat (3) step();
        exp_stall = exp_stall + 3;
        wb_valid = 1; wb_rd = 2'd1; wb_data = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (stall_count !== exp_stall[15:0]) begin
            failures++;
            $display("FAIL stall_count_incr: got %0d expected %0d", stall_count, exp_stall);
        end
        step();
        exp_stall = exp_stall + 1;
        wb_valid = 0;
        exp_q.push_back('{a:16'hBEEF, b:16'h0000, rd:2'd2, w:1'b1});
        @(negedge clk);
        checks++;
        if ({in_ready, rf_regWrite, stall_count} !== {1'b1, 1'b1, exp_stall[15:0]}) begin
            failures++;
            $display("FAIL raw_release: got ready=%b we=%b stall=%0d expected ready=1 we=1 stall=%0d",
                     in_ready, rf_regWrite, stall_count, exp_stall);
        end
        step();
        idle_inputs();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({op_valid, op_a, op_b, op_rd} !== {1'b1, e.a, e.b, e.rd}) begin
            failures++;
            $display("FAIL raw_bypass: got v=%b a=%h b=%h rd=%0d expected v=1 a=%h b=%h rd=%0d",
                     op_valid, op_a, op_b, op_rd, e.a, e.b, e.rd);
        end
        checks++;
        if ({busy_mask, stall_count} !== {4'b0100, exp_stall[15:0]}) begin
            failures++;
            $display("FAIL raw_busy: got busy=%b stall=%0d expected busy=0100 stall=%0d",
                     busy_mask, stall_count, exp_stall);
        end
    endtask

    task automatic test_collision();
        step();
        wb_valid = 1; wb_rd = 2'd2; wb_data = 16'h2222;
        step();
        wb_valid = 0;
        drive(2'd2, 2'd0, 2'd2, 1, 0, 1);
        exp_q.push_back('{a:16'h2222, b:16'h0000, rd:2'd2, w:1'b1});
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL collision_ready: got %b expected 1", in_ready);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (busy_mask !== 4'b0100) begin
            failures++;
            $display("FAIL collision_busy: got %b expected 0100", busy_mask);
        end
        e = exp_q.pop_front();
        checks++;
        if ({op_valid, op_a} !== {1'b1, e.a}) begin
            failures++;
            $display("FAIL collision_bypass: got v=%b a=%h expected v=1 a=%h", op_valid, op_a, e.a);
        end
        step();
        wb_valid = 1; wb_rd = 2'd2; wb_data = 16'h2200;
        step();
        wb_valid = 0;
        step();
        @(negedge clk);
        checks++;
        if (busy_mask !== 4'b0000) begin
            failures++;
            $display("FAIL collision_cleanup: got %b expected 0000", busy_mask);
        end
    endtask

    task automatic test_spurious();
        step();
        wb_valid = 1; wb_rd = 2'd0; wb_data = 16'hDEAD;
        step();
        wb_valid = 0;
        @(negedge clk);
        checks++;
        if ({rf_regWrite, err_wb} !== {1'b0, 1'b1}) begin
            failures++;
            $display("FAIL spurious_wb: got we=%b err=%b expected we=0 err=1", rf_regWrite, err_wb);
        end
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({err_wb, busy_mask} !== {1'b1, 4'b0000}) begin
            failures++;
            $display("FAIL err_sticky: got err=%b busy=%b expected err=1 busy=0000", err_wb, busy_mask);
        end
    endtask

    task automatic test_back_to_back();
        step();
        preload(2'd0, 16'h0011);
        preload(2'd3, 16'h0033);
        op_ready = 0;
        drive(2'd3, 2'd0, 2'd1, 1, 1, 1);
        exp_q.push_back('{a:16'h0033, b:16'h0011, rd:2'd1, w:1'b1});
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_first_ready: got %b expected 1", in_ready);
        end
        step();
        drive(2'd0, 2'd3, 2'd2, 1, 1, 1);
        exp_q.push_back('{a:16'h0011, b:16'h0033, rd:2'd2, w:1'b1});
        @(negedge clk);
        checks++;
        if ({in_ready, op_valid, op_a} !== {1'b0, 1'b1, exp_q[0].a}) begin
            failures++;
            $display("FAIL bp_blocked: got ready=%b v=%b a=%h expected ready=0 v=1 a=%h",
                     in_ready, op_valid, op_a, exp_q[0].a);
        end
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({op_valid, op_a, op_b, op_rd, stall_count} !==
            {1'b1, exp_q[0].a, exp_q[0].b, exp_q[0].rd, exp_stall[15:0]}) begin
            failures++;
            $display("FAIL bp_stable: got v=%b a=%h b=%h rd=%0d stall=%0d expected v=1 a=%h b=%h rd=%0d stall=%0d",
                     op_valid, op_a, op_b, op_rd, stall_count, exp_q[0].a, exp_q[0].b, exp_q[0].rd, exp_stall);
        end
        step();
        op_ready = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got %b expected 1", in_ready);
        end
        e = exp_q.pop_front();
        checks++;
        if ({op_a, op_b, op_rd, op_writes} !== {e.a, e.b, e.rd, e.w}) begin
            failures++;
            $display("FAIL bp_first_out: got a=%h b=%h rd=%0d expected a=%h b=%h rd=%0d",
                     op_a, op_b, op_rd, e.a, e.b, e.rd);
        end
        step();
        op_ready = 0;
        drive(2'd1, 2'd0, 2'd0, 1, 0, 0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({op_valid, op_a, op_b, op_rd} !== {1'b1, e.a, e.b, e.rd}) begin
            failures++;
            $display("FAIL bp_second_out: got v=%b a=%h b=%h rd=%0d expected v=1 a=%h b=%h rd=%0d",
                     op_valid, op_a, op_b, op_rd, e.a, e.b, e.rd);
        end
        checks++;
        if ({in_ready, busy_mask} !== {1'b0, 4'b0110}) begin
            failures++;
            $display("FAIL bp_busy: got ready=%b busy=%b expected ready=0 busy=0110", in_ready, busy_mask);
        end
    endtask

    task automatic test_async_reset();
        #1;
        reset = 1;
        #1;
        checks++;
        if ({op_valid, op_a, op_b, op_rd, op_writes, rf_regWrite, rf_rd, rf_writeData,
             busy_mask, stall_count, err_wb} !== '0) begin
            failures++;
            $display("FAIL async_reset: got v=%b a=%h rd=%0d wd=%h busy=%b stall=%0d err=%b expected all zero",
                     op_valid, op_a, rf_rd, rf_writeData, busy_mask, stall_count, err_wb);
        end
        exp_q.delete();
        idle_inputs();
        exp_stall = 0;
        repeat (2) step();
        reset = 0;
        preload(2'd3, 16'h0AB0);
        op_ready = 1;
        drive(2'd3, 2'd3, 2'd0, 1, 1, 1);
        exp_q.push_back('{a:16'h0AB0, b:16'h0AB0, rd:2'd0, w:1'b1});
        @(negedge clk);
        checks++;
        if ({in_ready, op_valid, busy_mask} !== {1'b1, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL restart_idle: got ready=%b v=%b busy=%b expected ready=1 v=0 busy=0000",
                     in_ready, op_valid, busy_mask);
        end
        step();
        idle_inputs();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({op_valid, op_a, op_b, op_rd, busy_mask, stall_count} !==
            {1'b1, e.a, e.b, e.rd, 4'b0001, exp_stall[15:0]}) begin
            failures++;
            $display("FAIL restart_issue: got v=%b a=%h b=%h rd=%0d busy=%b stall=%0d expected v=1 a=%h b=%h rd=%0d busy=0001 stall=%0d",
                     op_valid, op_a, op_b, op_rd, busy_mask, stall_count, e.a, e.b, e.rd, exp_stall);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_stall = 0;
        test_reset();
        test_independent();
        test_raw_stall();
        test_collision();
        test_spurious();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
